// File: rtl/wb_master_port_pkg.sv
// wb_master_port_pkg: shared state encoding and default timeout for the Wishbone initiator
package wb_master_port_pkg;
  typedef enum logic [1:0] {WBM_IDLE, WBM_BUS, WBM_RSP} wbm_state_e;
  localparam int WBM_DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/wb_master_port_if.sv
// wb_master_port_if: command, response and Wishbone bus signals of the initiator
interface wb_master_port_if #(parameter int ADDR_BITS = 8);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_BITS-1:2] cmd_addr;
  logic                 cmd_we;
  logic [3:0]           cmd_sel;
  logic [31:0]          cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic                 rsp_err;
  logic                 wbm_cs_o;
  logic [ADDR_BITS-1:2] wbm_addr_o;
  logic [3:0]           wbm_sel_o;
  logic [31:0]          wbm_data_o;
  logic                 wbm_we_o;
  logic [31:0]          wbm_data_i;
  logic                 wbm_ack_i;
  modport master (
    input  cmd_valid, cmd_addr, cmd_we, cmd_sel, cmd_data, rsp_ready, wbm_data_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, wbm_cs_o, wbm_addr_o, wbm_sel_o, wbm_data_o, wbm_we_o
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_we, cmd_sel, cmd_data, rsp_ready, wbm_data_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, wbm_cs_o, wbm_addr_o, wbm_sel_o, wbm_data_o, wbm_we_o
  );
endinterface

// File: rtl/wb_master_port.sv
// wb_master_port: turns one valid/ready command into one Wishbone access with ack timeout
module wb_master_port
  import wb_master_port_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int TIMEOUT   = WBM_DEFAULT_TIMEOUT
) (
  input logic             wbs_clk_i,
  input logic             rst,
  wb_master_port_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  wbm_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:2] addr_q, addr_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  assign bus.cmd_ready  = (state_q == WBM_IDLE) && !rst;
  assign bus.wbm_cs_o   = state_q == WBM_BUS;
  assign bus.rsp_valid  = state_q == WBM_RSP;
  assign bus.wbm_addr_o = addr_q;
  assign bus.wbm_sel_o  = sel_q;
  assign bus.wbm_data_o = wdata_q;
  assign bus.wbm_we_o   = we_q;
  assign bus.rsp_data   = rdata_q;
  assign bus.rsp_err    = err_q;
  // next state: latch command, wait for ack or timeout (ack wins a tie), hold response until taken
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      WBM_IDLE: if (bus.cmd_valid) begin
        state_d = WBM_BUS;
        cnt_d   = '0;
        addr_d  = bus.cmd_addr;
        sel_d   = bus.cmd_sel;
        wdata_d = bus.cmd_data;
        we_d    = bus.cmd_we;
      end
      WBM_BUS: begin
        cnt_d   = bus.wbm_ack_i ? cnt_q : cnt_q + 1'b1;
        state_d = (bus.wbm_ack_i || cnt_q == LAST) ? WBM_RSP : WBM_BUS;
        rdata_d = (bus.wbm_ack_i && !we_q) ? bus.wbm_data_i : 32'h0;
        err_d   = !bus.wbm_ack_i;
      end
      WBM_RSP: state_d = bus.rsp_ready ? WBM_IDLE : WBM_RSP;
      default: state_d = WBM_IDLE;
    endcase
  end
  // state and datapath registers; reset clears every output and discards any pending command
  always_ff @(posedge wbs_clk_i) begin
    if (rst) begin
      state_q <= WBM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_wb_master_port.sv
// tb_wb_master_port: directed bench with a responder, a response model and a per-cycle checker
module tb_wb_master_port;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  wb_master_port_if #(.ADDR_BITS(8)) bus();
  wb_master_port #(.ADDR_BITS(8), .TIMEOUT(TO)) dut (.wbs_clk_i(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [0:63];
  logic        r_ack = 1'b0;
  logic        ack_force = 1'b0;
  logic [31:0] r_dat = 32'h0;
  int          cyc = 0;
  int          resp_delay = 0;
  int          acc_total = 0;
  int          cs_total = 0;
  logic        outst = 1'b0;
  logic [32:0] exp_q [$];
  logic [31:0] last_data = 32'h0;
  logic        last_err = 1'b0;
  assign bus.wbm_ack_i  = r_ack | ack_force;
  assign bus.wbm_data_i = r_dat;

  task automatic chk(input string nm, input logic [32:0] a, input logic [32:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [32:0] model_rsp(input logic we, input int delay, input logic [31:0] rd);
    logic err;
    err = (delay + 2) > TO;
    return {err, (err || we) ? 32'h0 : rd};
  endfunction

  // responder acks a chosen number of idle cycles after it first sees cs, one access per ack
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0101_0101 * i;
      mem[1] <= 32'h1234_5678;
      mem[3] <= 32'h0000_1A5C;
      r_ack <= 1'b0;
      cyc <= 0;
    end else if (bus.wbm_cs_o && !r_ack) begin
      if (cyc == resp_delay) begin
        r_ack <= 1'b1;
        cyc <= 0;
        acc_total <= acc_total + 1;
        r_dat <= mem[bus.wbm_addr_o];
        for (int b = 0; b < 4; b++)
          if (bus.wbm_we_o && bus.wbm_sel_o[b]) mem[bus.wbm_addr_o][8*b +: 8] <= bus.wbm_data_o[8*b +: 8];
      end else cyc <= cyc + 1;
    end else begin
      r_ack <= 1'b0;
      cyc <= 0;
    end
  end

  // model: one expected response per accepted command; checks ready and responses every cycle
  always @(negedge clk) begin
    chk("cmd_ready", {32'h0, bus.cmd_ready}, {32'h0, !rst && !outst});
    if (bus.wbm_cs_o) cs_total++;
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) chk("stale_rsp", {bus.rsp_err, bus.rsp_data}, 33'h1_FFFF_FFFF);
      else begin
        chk("rsp", {bus.rsp_err, bus.rsp_data}, exp_q[0]);
        if (bus.rsp_ready) begin
          last_data = bus.rsp_data;
          last_err = bus.rsp_err;
          void'(exp_q.pop_front());
          outst = 1'b0;
        end
      end
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      exp_q.push_back(model_rsp(bus.cmd_we, resp_delay, mem[bus.cmd_addr]));
      outst = 1'b1;
    end
    if (rst) begin
      outst = 1'b0;
      exp_q.delete();
    end
  end

  task automatic issue(input logic we, input logic [7:2] addr, input logic [3:0] sel, input logic [31:0] data, input int delay);
    int n = 0;
    resp_delay = delay;
    bus.cmd_we = we;
    bus.cmd_addr = addr;
    bus.cmd_sel = sel;
    bus.cmd_data = data;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) chk("accept_timeout", 33'h0, 33'h1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy, cs0, acc0, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_we = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_sel = '0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b1;
    chk("model_read", model_rsp(1'b0, 0, 32'h0000_1A5C), 33'h0_0000_1A5C);
    chk("model_tie", model_rsp(1'b0, 2, 32'h0000_00AB), 33'h0_0000_00AB);
    chk("model_tmo", model_rsp(1'b0, 3, 32'h0000_00AB), 33'h1_0000_0000);
    chk("model_write", model_rsp(1'b1, 0, 32'h1234_5678), 33'h0_0000_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {bus.wbm_cs_o, bus.rsp_valid, bus.rsp_err, bus.wbm_we_o, bus.cmd_ready, bus.wbm_sel_o}, 33'h0);
    chk("rst_data", {1'b0, bus.rsp_data | bus.wbm_data_o | {26'h0, bus.wbm_addr_o}}, 33'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cs0 = cs_total; acc0 = acc_total;
    issue(1'b0, 6'd3, 4'hF, 32'h0, 0);
    count_busy(busy);
    chk("rd_busy", busy, 3);
    chk("rd_cs_cycles", cs_total - cs0, 2);
    chk("rd_accesses", acc_total - acc0, 1);
    chk("rd_data", {last_err, last_data}, 33'h0_0000_1A5C);
    cs0 = cs_total;
    issue(1'b1, 6'd1, 4'b0011, 32'hDEAD_BEEF, 0);
    count_busy(busy);
    chk("wr_busy", busy, 3);
    chk("wr_cs_cycles", cs_total - cs0, 2);
    chk("wr_mem", {1'b0, mem[1]}, 33'h0_1234_BEEF);
    chk("wr_rsp", {last_err, last_data}, 33'h0);
    cs0 = cs_total; acc0 = acc_total;
    issue(1'b0, 6'd5, 4'hF, 32'h0, 1000);
    count_busy(busy);
    chk("tmo_busy", busy, 5);
    chk("tmo_cs_cycles", cs_total - cs0, TO);
    chk("tmo_rsp", {last_err, last_data}, 33'h1_0000_0000);
    ack_force = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("late_ack_rsp_valid", {32'h0, bus.rsp_valid}, 33'h0);
    end
    @(posedge clk);
    #1 ack_force = 1'b0;
    chk("tmo_accesses", acc_total - acc0, 0);
    cs0 = cs_total;
    issue(1'b0, 6'd3, 4'hF, 32'h0, 2);
    count_busy(busy);
    chk("tie_cs_cycles", cs_total - cs0, TO);
    chk("tie_rsp", {last_err, last_data}, 33'h0_0000_1A5C);
    bus.rsp_ready = 1'b0;
    issue(1'b0, 6'd3, 4'hF, 32'h0, 0);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", {32'h0, bus.rsp_valid}, 33'h1);
    @(posedge clk);
    #1;
    acc0 = acc_total;
    bus.cmd_we = 1'b1;
    bus.cmd_addr = 6'd7;
    bus.cmd_sel = 4'hF;
    bus.cmd_data = 32'h55AA_55AA;
    bus.cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", {bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.wbm_cs_o, bus.rsp_data[28:0]}, {4'b1000, 29'h0000_1A5C});
    end
    chk("bp_no_access", acc_total - acc0, 0);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    count_busy(busy);
    chk("bp_next_busy", busy, 3);
    chk("bp_next_mem", {1'b0, mem[7]}, 33'h0_55AA_55AA);
    issue(1'b0, 6'd2, 4'hF, 32'h0, 1000);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst", {30'h0, bus.wbm_cs_o, bus.rsp_valid, bus.cmd_ready}, 33'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_rsp", {31'h0, bus.rsp_valid, bus.wbm_cs_o}, 33'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
